// File: rtl/replay_bus_distributor.sv
// Holds one replay packet and broadcasts it to CHANNEL_CNT replayers, retiring it once every
// channel has accepted it. Define REPLAY_DIST_PERF_EN to add the pkt_cnt/stall_cnt counters.
module replay_bus_distributor #(
  parameter int CHANNEL_CNT = 4,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            replay_en,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [CHANNEL_CNT-1:0]          in_logb_valid,
  input  logic [CHANNEL_CNT*DATA_WIDTH-1:0] in_logb_data,
  input  logic [CHANNEL_CNT-1:0]          in_loge_valid,
  output logic [CHANNEL_CNT-1:0]          out_valid,
  input  logic [CHANNEL_CNT-1:0]          out_ready,
  output logic [CHANNEL_CNT-1:0]          out_logb_valid,
  output logic [CHANNEL_CNT*DATA_WIDTH-1:0] out_logb_data,
  output logic [CHANNEL_CNT-1:0]          out_loge_valid,
  output logic                            busy
`ifdef REPLAY_DIST_PERF_EN
  ,
  output logic [31:0]                     pkt_cnt,
  output logic [31:0]                     stall_cnt
`endif
);

  typedef enum logic {
    EMPTY     = 1'b0,
    BROADCAST = 1'b1
  } state_e;

  state_e                          state_q;
  logic [CHANNEL_CNT-1:0]          done_q;
  logic [CHANNEL_CNT-1:0]          logb_valid_q;
  logic [CHANNEL_CNT-1:0]          loge_valid_q;
  logic [CHANNEL_CNT*DATA_WIDTH-1:0] logb_data_q;

  logic                            hold_valid;
  logic [CHANNEL_CNT-1:0]          accept;
  logic                            retire;
  logic                            capture;

  assign hold_valid = (state_q == BROADCAST);
  assign out_valid  = {CHANNEL_CNT{hold_valid}} & ~done_q;
  assign accept     = out_valid & out_ready;
  // Retire in the same cycle the last outstanding channel accepts, so a new packet can follow.
  assign retire     = hold_valid & (&(done_q | accept));
  assign in_ready   = replay_en & ~rst & (~hold_valid | retire);
  assign capture    = in_valid & in_ready;
  assign busy       = hold_valid;

  assign out_logb_valid = logb_valid_q;
  assign out_logb_data  = logb_data_q;
  assign out_loge_valid = loge_valid_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      done_q  <= '0;
    end else begin
      case (state_q)
        EMPTY:     if (capture) state_q <= BROADCAST;
        BROADCAST: if (retire && !capture) state_q <= EMPTY;
      endcase
      done_q <= retire ? '0 : (done_q | accept);
    end
  end

  // NOTE: payload registers carry no reset; they are only observed while hold_valid is set.
  always_ff @(posedge clk) begin
    if (capture) begin
      logb_valid_q <= in_logb_valid;
      logb_data_q  <= in_logb_data;
      loge_valid_q <= in_loge_valid;
    end
  end

`ifdef REPLAY_DIST_PERF_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_q + {31'd0, retire};
      stall_cnt_q <= stall_cnt_q + {31'd0, hold_valid & ~retire};
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
